mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port unified memory between the CPU's instruction-fetch port and its load/store port, one transaction in flight at a time. Sits inside `top` between the core and the memory model. Data accesses have priority, fetch is protected by a starvation counter, and a watchdog fails any transaction the memory never answers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits
- TIMEOUT, 64, cycles from issue to forced error completion

- clk  in  1  clock, rising edge; one clock domain
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid, one cycle
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  load/store request; held until d_gnt
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid or store acknowledge, one cycle
- d_rdata  out  DATA_W  load data
- err  out  1  one-cycle pulse with the timed-out requester's rvalid
- mem_req  out  1  memory command, one cycle per transaction
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  command fields
- mem_rvalid  in  1  memory completion, reads and writes
- mem_rdata  in  DATA_W  read data

## Operation
- FSM states: IDLE, BUSY.
- IDLE:
  - If any request is present, pick a winner, assert mem_req and the winner's gnt combinationally in the same cycle, latch owner, go to BUSY.
  - mem_we/mem_wdata/mem_be are forced 0 for a fetch.
- Arbitration:
  - d_req wins by default.
  - Exception: if_req wins when streak == STARVE_MAX.
- streak counter, 0..STARVE_MAX, saturating:
  - Increments when data is granted while if_req = 1.
  - Clears when fetch is granted or when data is granted with if_req = 0.
- BUSY:
  - New requests are not granted.
  - mem_rvalid ends the transaction: owner's rvalid = 1 and owner's rdata = mem_rdata in that cycle (combinational pass-through). Next state is IDLE.
  - The non-owner's rvalid stays 0.
- Watchdog:
  - wd counter clears on issue and increments each BUSY cycle.
  - When wd reaches TIMEOUT-1 with no mem_rvalid, owner's rvalid = 1, rdata = 0, err = 1, and the FSM returns to IDLE.
  - A later stray mem_rvalid in IDLE is ignored.
- mem_rvalid in IDLE is always ignored: no rvalid, no err.
- Reset:
  - All outputs are forced 0 while reset = 1.
  - State ← IDLE, streak ← 0, wd ← 0, owner ← fetch.
  - Reset mid-BUSY abandons the transaction; its late completion is dropped.

## Timing
- Grant latency 0 cycles from request in IDLE. The requester drops or changes its request in the cycle after gnt.
- Response latency equals memory latency: rvalid appears in the cycle mem_rvalid arrives.
- Back-to-back: the next grant is possible in the cycle after the response. Minimum spacing between issues is 2 cycles with a zero-wait memory (mem_rvalid the cycle after mem_req).
- mem_req is never high in two consecutive cycles.
- At most one transaction outstanding.
- Simultaneous mem_rvalid and timeout in the same cycle: mem_rvalid wins, err = 0, data delivered.

## Test plan
- Reset held 3 cycles with if_req = d_req = 1 → all outputs 0 throughout. First cycle after release: d_gnt = 1, mem_req = 1, mem_addr = d_addr.
- Fetch alone: if_addr = 0x100, memory returns 0xDEADBEEF 2 cycles later → if_gnt in cycle 0, if_rvalid = 1 with if_rdata = 0xDEADBEEF in cycle 2, d_rvalid = 0.
- Store: d_we = 1, d_addr = 0x2000, d_wdata = 0x12345678, d_be = 4'b0011 → mem_we/mem_be/mem_wdata match. d_rvalid pulses on mem_rvalid; if_rvalid never asserts.
- Starvation: both requests held continuously, STARVE_MAX = 4 → grant order D, D, D, D, IF, D, D, D, D, IF…; streak reads 0 after each IF grant.
- Timeout: TIMEOUT = 8, memory never answers a fetch → if_rvalid = 1, if_rdata = 0, err = 1 exactly 8 cycles after issue. A stray mem_rvalid 3 cycles later produces no output.
- Reset mid-BUSY: reset asserted for 1 cycle after a data issue, memory completes 2 cycles later → d_rvalid stays 0, and the next request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the CPU instruction-fetch port and its
// load/store port. Only one transaction is in flight at a time.
//   * Data requests win by default; fetch is protected by a streak counter that
//     forces a fetch grant after STARVE_MAX consecutive data grants during
//     which fetch was waiting.
//   * A watchdog completes a transaction with an error when the memory does
//     not answer within TIMEOUT cycles of issue.
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   if_req/if_addr        : fetch request, held until if_gnt
//   if_gnt                : fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata    : fetch completion, one cycle
//   d_req/d_we/d_addr     : load/store request, held until d_gnt
//   d_wdata/d_be          : store data and byte enables
//   d_gnt                 : load/store accepted this cycle (combinational)
//   d_rvalid/d_rdata      : load data or store acknowledge, one cycle
//   err                   : pulses together with the owner's rvalid on timeout
//   mem_req/mem_we/...    : memory command, one cycle per transaction
//   mem_rvalid/mem_rdata  : memory completion for reads and writes
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction fetch port
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  // load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  err,
  // memory side
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);
  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [WW-1:0]   wd_q, wd_d;

  logic fetch_wins_s;
  logic issue_s;
  logic busy_s;
  logic done_s;
  logic timeout_s;
  logic finish_s;

  // Fetch only beats a present data request once the streak has saturated.
  assign fetch_wins_s = if_req & (~d_req | (streak_q == STREAK_MAX));

  // Every event is gated by reset so all outputs are quiet while it is held.
  assign issue_s   = ~reset & (state_q == IDLE) & (if_req | d_req);
  assign busy_s    = ~reset & (state_q == BUSY);
  assign done_s    = busy_s & mem_rvalid;
  // A real completion in the watchdog's last cycle takes precedence.
  assign timeout_s = busy_s & ~mem_rvalid & (wd_q == WD_LAST);
  assign finish_s  = done_s | timeout_s;

  // Next-state, owner, streak and watchdog computation.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    wd_d     = wd_q;
    case (state_q)
      IDLE: begin
        if (issue_s) begin
          state_d = BUSY;
          owner_d = fetch_wins_s ? OWNER_FETCH : OWNER_DATA;
          wd_d    = '0;
          if (fetch_wins_s) begin
            streak_d = '0;
          end else if (if_req) begin
            // Data won while fetch waited: count it, saturating.
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        wd_d = wd_q + 1'b1;
        if (finish_s) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_FETCH;
      streak_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      wd_q     <= wd_d;
    end
  end

  // Grant and memory command, issued in the same cycle as the request.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (issue_s) begin
      mem_req = 1'b1;
      if (fetch_wins_s) begin
        // Fetches are reads: write fields stay zero.
        if_gnt   = 1'b1;
        mem_addr = if_addr;
      end else begin
        d_gnt     = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_be    = d_be;
      end
    end else begin
      mem_req = 1'b0;
    end
  end

  // Completion routing to the owner; timeout returns zero data with err.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    err       = 1'b0;
    if (finish_s) begin
      err = timeout_s;
      if (owner_q == OWNER_DATA) begin
        d_rvalid = 1'b1;
        d_rdata  = done_s ? mem_rdata : '0;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = done_s ? mem_rdata : '0;
      end
    end else begin
      err = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives the arbiter from a requester/memory model: the driver issues requests,
// predicts the winner from the arbitration rules and queues the response it
// expects (owner, data, err, arrival cycle). An independent monitor pops the
// queue whenever the DUT presents a response and compares.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int SMAX = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_d;
    logic [DW-1:0] data;
    bit            err;
    int            due;
  } exp_t;

  exp_t sb[$];

  // Requester model: pending requests are held until granted.
  bit            pend_if  = 1'b0;
  bit            pend_d   = 1'b0;
  logic [AW-1:0] pif_addr = '0;
  bit            pd_we    = 1'b0;
  logic [AW-1:0] pd_addr  = '0;
  logic [DW-1:0] pd_wdata = '0;
  logic [BW-1:0] pd_be    = '0;
  // Consecutive data grants while fetch was waiting, capped at SMAX.
  int            streak_m = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    if_req  = pend_if;
    if_addr = pif_addr;
    d_req   = pend_d;
    d_we    = pd_we;
    d_addr  = pd_addr;
    d_wdata = pd_wdata;
    d_be    = pd_be;
  endtask

  task automatic new_fetch(input logic [AW-1:0] a);
    pend_if  = 1'b1;
    pif_addr = a;
  endtask

  task automatic new_data(input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [BW-1:0] be);
    pend_d   = 1'b1;
    pd_we    = we;
    pd_addr  = a;
    pd_wdata = wd;
    pd_be    = be;
  endtask

  // Present pending requests in an idle cycle and check the grant and command.
  task automatic issue_only(output bit won_d);
    bit exp_if;
    drive_reqs();
    @(negedge clk);
    exp_if = pend_if && (!pend_d || (streak_m == SMAX));
    cmp("if_gnt", 64'(if_gnt), 64'(exp_if));
    cmp("d_gnt", 64'(d_gnt), 64'(!exp_if));
    cmp("mem_req", 64'(mem_req), 64'd1);
    if (exp_if) begin
      cmp("mem_addr_if", 64'(mem_addr), 64'(pif_addr));
      cmp("mem_cmd_if_zero", 64'({mem_we, mem_be, mem_wdata}), 64'd0);
      streak_m = 0;
      pend_if  = 1'b0;
      won_d    = 1'b0;
    end else begin
      cmp("mem_addr_d", 64'(mem_addr), 64'(pd_addr));
      cmp("mem_we", 64'(mem_we), 64'(pd_we));
      if (pd_we) begin
        cmp("mem_wdata", 64'(mem_wdata), 64'(pd_wdata));
        cmp("mem_be", 64'(mem_be), 64'(pd_be));
      end
      streak_m = pend_if ? ((streak_m < SMAX) ? streak_m + 1 : SMAX) : 0;
      pend_d   = 1'b0;
      won_d    = 1'b1;
    end
  endtask

  // One full transaction; lat = cycles until mem_rvalid, 0 = memory never answers.
  task automatic run_txn(input int lat, input logic [DW-1:0] rd, output bit won_d);
    exp_t e;
    int   span;
    issue_only(won_d);
    span   = (lat == 0) ? TMO : lat;
    e.is_d = won_d;
    e.data = (lat == 0) ? '0 : rd;
    e.err  = (lat == 0);
    e.due  = cyc + span;
    sb.push_back(e);
    for (int k = 1; k <= span; k++) begin
      next_cycle();
      drive_reqs();
      mem_rvalid = (k == lat);
      mem_rdata  = (k == lat) ? rd : DW'($urandom);
      @(negedge clk);
      cmp("busy_quiet", 64'({if_gnt, d_gnt, mem_req}), 64'd0);
    end
    next_cycle();
    mem_rvalid = 1'b0;
  endtask

  // Cycles with no request; optional stray mem_rvalid at index stray_at.
  task automatic idle(input int n, input int stray_at);
    for (int k = 0; k < n; k++) begin
      if_req     = 1'b0;
      d_req      = 1'b0;
      mem_rvalid = (k == stray_at);
      mem_rdata  = DW'($urandom);
      @(negedge clk);
      cmp("idle_quiet", 64'({if_gnt, d_gnt, mem_req}), 64'd0);
      next_cycle();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      drive_reqs();
      mem_rvalid = 1'b1;
      mem_rdata  = DW'($urandom);
      @(negedge clk);
      cmp("reset_outputs_zero",
          64'({if_gnt, if_rvalid, d_gnt, d_rvalid, err, mem_req, mem_we,
               (|mem_addr), (|mem_wdata), (|mem_be), (|if_rdata), (|d_rdata)}),
          64'd0);
      next_cycle();
    end
    reset      = 1'b0;
    mem_rvalid = 1'b0;
    streak_m   = 0;
    sb.delete();
  endtask

  // Monitor: every presented response must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (if_rvalid || d_rvalid || err) begin
        if (sb.size() == 0) begin
          cmp("unexpected_response", 64'({if_rvalid, d_rvalid, err}), 64'd0);
        end else begin
          e = sb.pop_front();
          cmp("resp_cycle", 64'(cyc), 64'(e.due));
          cmp("resp_owner", 64'({if_rvalid, d_rvalid}), e.is_d ? 64'd1 : 64'd2);
          cmp("resp_data", e.is_d ? 64'(d_rdata) : 64'(if_rdata), 64'(e.data));
          cmp("resp_err", 64'(err), 64'(e.err));
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        cmp("resp_deadline", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  initial begin : time_limit
    #500000;
    $display("FAIL time_limit: simulation did not complete");
    $fatal(1);
  end

  initial begin : driver
    bit won;
    int lats [8] = '{1, 1, 2, 3, 4, TMO, 0, 1};
    int lat;

    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset with both requesters active: quiet outputs, then data wins first.
    new_fetch(32'h0000_0100);
    new_data(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    hold_reset(3);
    run_txn(1, 32'hCAFE_0001, won);
    cmp("first_grant_is_data", 64'(won), 64'd1);

    // Fetch alone (left pending from above), memory answers after 2 cycles.
    run_txn(2, 32'hDEAD_BEEF, won);
    cmp("fetch_alone_winner", 64'(won), 64'd0);

    // Store with partial byte enables.
    new_data(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011);
    run_txn(1, 32'h0, won);
    cmp("store_winner", 64'(won), 64'd1);

    // Starvation: both held continuously, fetch wins every fifth grant.
    for (int i = 0; i < 10; i++) begin
      if (!pend_if) new_fetch($urandom);
      if (!pend_d) new_data(1'($urandom), $urandom, $urandom, BW'($urandom));
      run_txn(1, $urandom, won);
      cmp("starve_order", 64'(won), 64'((i % 5) != 4));
    end
    // Flush the leftover data request so the fetch below is alone.
    run_txn(1, $urandom, won);

    // Watchdog: fetch never answered, then a stray completion is ignored.
    new_fetch(32'h0000_0300);
    run_txn(0, 32'h0, won);
    idle(4, 2);

    // Reset one cycle after a data issue; late completion must be dropped.
    new_data(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    issue_only(won);
    next_cycle();
    hold_reset(1);
    idle(2, 0);
    new_data(1'b0, 32'h0000_6000, 32'h0, 4'h0);
    run_txn(1, 32'hA5A5_5A5A, won);
    cmp("grant_after_midbusy_reset", 64'(won), 64'd1);

    // Randomized traffic, latencies and stray completions.
    for (int t = 0; t < 200; t++) begin
      if (!pend_if && ($urandom_range(0, 1) != 0)) new_fetch($urandom);
      if (!pend_d && ($urandom_range(0, 2) != 0))
        new_data(1'($urandom), $urandom, $urandom, BW'($urandom));
      if (!pend_if && !pend_d) begin
        idle($urandom_range(1, 3), $urandom_range(0, 3));
      end else begin
        lat = lats[$urandom_range(0, 7)];
        run_txn(lat, $urandom, won);
      end
    end

    @(negedge clk);
    cmp("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
